// File: rtl/busytable_mp.sv
// rtl/busytable_mp.sv - physical-register busy table with read bypass; BUSYTABLE_DLY_WAKE_EN adds the delayed-wakeup pipeline
`ifndef ROB_STATE_NORMAL
`define ROB_STATE_NORMAL        2'd0
`endif
`ifndef ROB_STATE_WALK
`define ROB_STATE_WALK          2'd1
`endif
`ifndef ROB_STATE_OVERWRITE_RAT
`define ROB_STATE_OVERWRITE_RAT 2'd2
`endif

module busytable_mp #(
    parameter int PREG_NUM        = 64,
    parameter int PREG_W          = 6,
    parameter int NRD             = 4,
    parameter int NAL             = 2,
    parameter int NFR             = 2,
    parameter int NWK             = 2,
    parameter int MAX_DLY         = 3,
    parameter bit ZERO_PREG_READY = 1'b1,
    parameter int CNT_W           = $clog2(NFR*MAX_DLY+1)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NRD*PREG_W-1:0] read_addr,
    output logic [NRD-1:0]        busy_out,
    input  logic [NAL-1:0]        alloc_en,
    input  logic [NAL*PREG_W-1:0] alloc_addr,
    input  logic [NFR-1:0]        free_en,
    input  logic [NFR*PREG_W-1:0] free_addr,
    input  logic [NFR*2-1:0]      free_dly,
    input  logic [1:0]            rob_state,
    input  logic [NWK-1:0]        rob_walk_valid,
    input  logic [NWK*PREG_W-1:0] rob_walk_prd,
    output logic [CNT_W-1:0]      pend_cnt
);

    logic [PREG_NUM-1:0]          busy_q, busy_d;
    logic                         overwrite;
    logic [NFR-1:0]               imm_free;
    logic [NFR-1:0]               exp_v;
    logic [NFR-1:0][PREG_W-1:0]   exp_a;

    assign overwrite = (rob_state == `ROB_STATE_OVERWRITE_RAT);

`ifdef BUSYTABLE_DLY_WAKE_EN
    // Per free port: stage 0 is the expiring slot; entries shift one stage toward it per cycle.
    logic [NFR-1:0][MAX_DLY-1:0]             pv_q, pv_d;
    logic [NFR-1:0][MAX_DLY-1:0][PREG_W-1:0] pa_q, pa_d;
    logic [CNT_W-1:0]                        cnt_q, cnt_d;

    always_comb begin
        int dly;
        dly      = 0;
        pv_d     = '0;
        pa_d     = pa_q;
        cnt_d    = '0;
        imm_free = '0;
        exp_v    = '0;
        exp_a    = '0;
        for (int j = 0; j < NFR; j++) begin
            dly = int'(free_dly[2*j +: 2]);
            if (dly > MAX_DLY) dly = MAX_DLY;
            imm_free[j] = free_en[j] && (dly == 0);
            exp_v[j]    = pv_q[j][0];
            exp_a[j]    = pa_q[j][0];
            pv_d[j]     = pv_q[j] >> 1;
            pa_d[j]     = pa_q[j] >> PREG_W;
            // A shifting entry already owns the target stage; the new request is dropped.
            for (int s = 0; s < MAX_DLY; s++) begin
                if (free_en[j] && (dly == s + 1) && !pv_d[j][s]) begin
                    pv_d[j][s] = 1'b1;
                    pa_d[j][s] = free_addr[j*PREG_W +: PREG_W];
                end
            end
        end
        if (overwrite) pv_d = '0;
        for (int j = 0; j < NFR; j++) begin
            for (int s = 0; s < MAX_DLY; s++) begin
                cnt_d = cnt_d + CNT_W'(pv_d[j][s]);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pv_q  <= '0;
            pa_q  <= '0;
            cnt_q <= '0;
        end else begin
            pv_q  <= pv_d;
            pa_q  <= pa_d;
            cnt_q <= cnt_d;
        end
    end

    assign pend_cnt = cnt_q;
`else
    logic unused_free_dly;

    always_comb begin
        imm_free = free_en;
        exp_v    = '0;
        exp_a    = '0;
    end

    assign pend_cnt        = '0;
    assign unused_free_dly = ^free_dly;
`endif

    // Later loops win: alloc, then immediate free, expiry, walk; overwrite beats all.
    always_comb begin
        busy_d = busy_q;
        for (int a = 0; a < NAL; a++) begin
            if (alloc_en[a]) busy_d[alloc_addr[a*PREG_W +: PREG_W]] = 1'b1;
        end
        for (int j = 0; j < NFR; j++) begin
            if (imm_free[j]) busy_d[free_addr[j*PREG_W +: PREG_W]] = 1'b0;
        end
        for (int j = 0; j < NFR; j++) begin
            if (exp_v[j]) busy_d[exp_a[j]] = 1'b0;
        end
        for (int w = 0; w < NWK; w++) begin
            if (rob_walk_valid[w]) busy_d[rob_walk_prd[w*PREG_W +: PREG_W]] = 1'b0;
        end
        if (ZERO_PREG_READY) busy_d[0] = 1'b0;
        if (overwrite) busy_d = '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) busy_q <= '0;
        else          busy_q <= busy_d;
    end

    always_comb begin
        logic [PREG_W-1:0] ra;
        logic              hit;
        ra       = '0;
        hit      = 1'b0;
        busy_out = '0;
        for (int i = 0; i < NRD; i++) begin
            ra  = read_addr[i*PREG_W +: PREG_W];
            hit = 1'b0;
            for (int j = 0; j < NFR; j++) begin
                if (imm_free[j] && (free_addr[j*PREG_W +: PREG_W] == ra)) hit = 1'b1;
                if (exp_v[j] && (exp_a[j] == ra)) hit = 1'b1;
            end
            if (ZERO_PREG_READY && (ra == '0)) hit = 1'b1;
            busy_out[i] = busy_q[ra] & ~hit;
        end
    end

endmodule
